iahb_lite_master: RTL and testbench
===================================

Name: iahb_lite_master

Overview:
- AHB-lite initiator that converts a simple valid/ready request interface into pipelined single transfers on the instruction-memory AHB-lite bus.
- Intended users: boot loader, self-test engine and debug access port, driving the memory controller's lite_* slave port through the bus decoder.
- Supports byte, halfword and word transfers, overlapped address and data phases, slave wait states and ERROR responses.
- Returns one response per request, in issue order.

Parameters:
- ADDR_WIDTH, 32, width of request and bus address (upper bits zero-extended onto HADDR[31:0]).
- RESP_ON_WRITE, 1, 1 = writes also produce a response pulse; 0 = only reads and errors do.

Ports:
- pll_core_cpuclk  in  1  clock
- pad_cpu_rst_b  in  1  reset, asynchronous, active-low
- pad_biu_bigend_b  in  1  0 = big-endian lane mapping, 1 = little-endian
- req_vld  in  1  request valid
- req_rdy  out  1  request accepted when req_vld && req_rdy
- req_write  in  1  1 = write
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  3  0 = byte, 1 = half, 2 = word; others illegal
- req_wdata  in  32  right-justified write data
- resp_vld  out  1  one-cycle response pulse
- resp_rdata  out  32  read data, right-justified, zero-extended
- resp_err  out  1  bus ERROR or illegal request
- mst_yy_haddr  out  32  HADDR
- mst_yy_htrans  out  2  HTRANS: 00 IDLE, 10 NONSEQ only
- mst_yy_hsize  out  3  HSIZE
- mst_yy_hwrite  out  1  HWRITE
- mst_yy_hwdata  out  32  HWDATA
- mst_hrdata  in  32  HRDATA
- mst_hready  in  1  HREADY
- mst_hresp  in  2  HRESP: 00 OKAY, 01 ERROR

Behaviour:
- Two pipeline registers:
  - A (address phase): a_vld, a_phantom, addr, size, write, wdata.
  - D (data phase): d_vld, d_phantom, addr, size, write, wdata.
- Reset values: a_vld = d_vld = 0; all bus outputs 0 (htrans IDLE); req_rdy = 1; resp_vld = resp_err = 0; resp_rdata = 0.
- req_rdy = !a_vld || (mst_hready && !err_cancel). Purely combinational from state and mst_hready; does not depend on req_vld.
- Accept:
  - Legal request: loads A, a_phantom = 0.
  - Illegal request loads A with a_phantom = 1. Illegal means size > 2, size 1 with addr[0] = 1, or size 2 with addr[1:0] != 0.
- Bus drive:
  - htrans = 10 when a_vld && !a_phantom && !err_cancel, else 00.
  - haddr, hsize, hwrite are driven from A.
  - Bus outputs are held stable while mst_hready = 0.
- Advance on mst_hready = 1:
  - D <= A (d_vld <= a_vld).
  - A <= accepted request, or invalid if none.
  - Zero-bubble back-to-back: address of N+1 is on the bus during the data phase of N.
- hwdata is driven from D:
  - byte: replicated {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
  - Lane selection is left to the slave, so hwdata is endian-agnostic.
- Response, in the cycle d_vld && mst_hready:
  - resp_vld = 1 (for writes only when RESP_ON_WRITE = 1).
  - resp_err = d_phantom || (mst_hresp == 01).
  - Reads select the lane as follows. Little-endian: byte lane = addr[1:0], half lane = addr[1]. Big-endian: byte lane = 3 - addr[1:0], half lane = !addr[1].
  - resp_rdata = 0 on error.
- Phantom transfers never reach the bus.
  - They still occupy A then D, which keeps responses in order.
  - They complete on the first mst_hready = 1 in D.
- ERROR, two-cycle:
  - First cycle: d_vld && !mst_hready && mst_hresp == 01. Set err_cancel for that cycle. htrans is forced to 00 in the following cycle; the A contents are retained, not dropped.
  - Second cycle (hready = 1, hresp = 01): error response for D. A advances to D only if it was not cancelled; a cancelled A stays in A and is reissued as NONSEQ the next cycle.
- Simultaneous accept and response in one cycle is legal.
- Reset mid-transfer clears everything immediately; no response is issued for in-flight requests.
- Responses never overtake: at most 2 requests outstanding (A + D).

Decomposition:
- Shared package iahb_pkg:
  - HTRANS_IDLE / HTRANS_NONSEQ
  - HSIZE_BYTE / HALF / WORD
  - HRESP_OKAY / ERROR
  - function size_legal(size, addr[1:0])
- One sub-module: iahb_lane_sel (combinational read-lane extraction and write replication, given endian, size, addr).

Test Plan:
- Little-endian word write 0x1234_5678 @0x100, then byte read @0x101. Required: NONSEQ in consecutive cycles, hwdata = 0x12345678 in cycle 2, read resp_rdata = 0x0000_0056, resp_err = 0.
- Big-endian (bigend_b = 0) byte read @0x100 with hrdata = 0xAABBCCDD -> resp_rdata = 0x0000_00AA; half read @0x102 -> 0x0000_CCDD.
- Slave holds hready = 0 for 3 cycles during a read data phase, with a second request pending. Required: haddr/htrans of the second request stable for all 3 cycles, req_rdy = 0, exactly 2 resp_vld pulses, in order.
- Illegal word request @0x102 between two legal reads. Required: no NONSEQ for @0x102, 3 responses in order, the middle one with resp_err = 1.
- Two-cycle ERROR on the first of two back-to-back writes. Required: htrans = 00 in the cycle after the first ERROR cycle, second write reissued as NONSEQ, responses err = 1 then err = 0.
- Assert pad_cpu_rst_b low while a_vld && d_vld. Required: htrans = 00, resp_vld = 0, req_rdy = 1 immediately; no stale response after reset release.

Source files
------------

// File: rtl/iahb_lite_master_pkg.sv
// Shared constants and helpers for the instruction-side AHB-lite initiator.
package iahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    function automatic logic size_legal(
        input logic [2:0] size,
        input logic [1:0] lo
    );
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            size == HSIZE_BYTE: ok = 1'b1;
            size == HSIZE_HALF: ok = !lo[0];
            size == HSIZE_WORD: ok = (lo == 2'b00);
            default:            ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/iahb_lite_master_if.sv
// AHB-lite bus bundle between the initiator and the bus decoder.
interface iahb_lite_master_if;

    logic [31:0] mst_yy_haddr;
    logic [1:0]  mst_yy_htrans;
    logic [2:0]  mst_yy_hsize;
    logic        mst_yy_hwrite;
    logic [31:0] mst_yy_hwdata;
    logic [31:0] mst_hrdata;
    logic        mst_hready;
    logic [1:0]  mst_hresp;

    modport master (
        output mst_yy_haddr,
        output mst_yy_htrans,
        output mst_yy_hsize,
        output mst_yy_hwrite,
        output mst_yy_hwdata,
        input  mst_hrdata,
        input  mst_hready,
        input  mst_hresp
    );

    modport slave (
        input  mst_yy_haddr,
        input  mst_yy_htrans,
        input  mst_yy_hsize,
        input  mst_yy_hwrite,
        input  mst_yy_hwdata,
        output mst_hrdata,
        output mst_hready,
        output mst_hresp
    );

endinterface

// File: rtl/iahb_lite_master_lane_sel.sv
// Read-lane extraction and write-lane replication for the data phase.
module iahb_lane_sel
    import iahb_pkg::*;
(
    input  logic        bigend_b,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] hrdata,
    output logic [31:0] rdata,
    output logic [31:0] hwdata
);

    logic [1:0] byte_lane;
    logic       half_lane;

    // Big-endian lane index is the mirror of the little-endian one.
    assign byte_lane = bigend_b ? addr_lo : ~addr_lo;
    assign half_lane = bigend_b ? addr_lo[1] : ~addr_lo[1];

    always_comb begin
        rdata  = hrdata;
        hwdata = wdata;
        unique case (1'b1)
            size == HSIZE_BYTE: begin
                rdata  = {24'b0, hrdata[{byte_lane, 3'b000} +: 8]};
                hwdata = {4{wdata[7:0]}};
            end
            size == HSIZE_HALF: begin
                rdata  = {16'b0, hrdata[{half_lane, 4'b0000} +: 16]};
                hwdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/iahb_lite_master.sv
// Valid/ready request port to pipelined AHB-lite single transfers.
module iahb_lite_master
    import iahb_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter bit RESP_ON_WRITE = 1'b1
) (
    input  logic                  pll_core_cpuclk,
    input  logic                  pad_cpu_rst_b,
    input  logic                  pad_biu_bigend_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_size,
    input  logic [31:0]           req_wdata,
    output logic                  resp_vld,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    iahb_lite_master_if.master    bus
);

    logic                  a_vld;
    logic                  a_phantom;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [2:0]            a_size;
    logic                  a_write;
    logic [31:0]           a_wdata;

    logic                  d_vld;
    logic                  d_phantom;
    logic [1:0]            d_addr_lo;
    logic [2:0]            d_size;
    logic                  d_write;
    logic [31:0]           d_wdata;

    logic                  err_cancel;
    logic                  accept;
    logic                  advance;
    logic                  d_fire;
    logic                  bus_err;
    logic [31:0]           lane_rdata;

    assign advance = bus.mst_hready && !err_cancel;
    assign req_rdy = !a_vld || advance;
    assign accept  = req_vld && req_rdy;
    assign bus_err = (bus.mst_hresp == HRESP_ERROR);
    assign d_fire  = d_vld && bus.mst_hready;

    assign bus.mst_yy_htrans = (a_vld && !a_phantom && !err_cancel)
                             ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.mst_yy_haddr  = 32'(a_addr);
    assign bus.mst_yy_hsize  = a_size;
    assign bus.mst_yy_hwrite = a_write;

    iahb_lane_sel u_lane_sel (
        .bigend_b (pad_biu_bigend_b),
        .size     (d_size),
        .addr_lo  (d_addr_lo),
        .wdata    (d_wdata),
        .hrdata   (bus.mst_hrdata),
        .rdata    (lane_rdata),
        .hwdata   (bus.mst_yy_hwdata)
    );

    assign resp_err   = d_fire && (d_phantom || bus_err);
    assign resp_vld   = d_fire && (!d_write || RESP_ON_WRITE || resp_err);
    assign resp_rdata = (d_fire && !resp_err && !d_write) ? lane_rdata : 32'b0;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            a_vld      <= 1'b0;
            a_phantom  <= 1'b0;
            a_addr     <= '0;
            a_size     <= 3'b0;
            a_write    <= 1'b0;
            a_wdata    <= 32'b0;
            d_vld      <= 1'b0;
            d_phantom  <= 1'b0;
            d_addr_lo  <= 2'b0;
            d_size     <= 3'b0;
            d_write    <= 1'b0;
            d_wdata    <= 32'b0;
            err_cancel <= 1'b0;
        end else begin
            // First ERROR cycle: the next address phase must go IDLE.
            err_cancel <= d_vld && !bus.mst_hready && bus_err;
            if (bus.mst_hready) begin
                d_vld <= advance && a_vld;
            end
            if (advance) begin
                d_phantom <= a_phantom;
                d_addr_lo <= a_addr[1:0];
                d_size    <= a_size;
                d_write   <= a_write;
                d_wdata   <= a_wdata;
            end
            if (accept) begin
                a_vld     <= 1'b1;
                a_phantom <= !size_legal(req_size, req_addr[1:0]);
                a_addr    <= req_addr;
                a_size    <= req_size;
                a_write   <= req_write;
                a_wdata   <= req_wdata;
            end else if (advance) begin
                a_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iahb_lite_master.sv
// Directed bench for iahb_lite_master with hand-computed expectations.
module tb_iahb_lite_master;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        bigend_b;
    logic        req_vld;
    logic        req_rdy;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_vld;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int failures = 0;

    iahb_lite_master_if bus ();

    iahb_lite_master #(
        .ADDR_WIDTH    (32),
        .RESP_ON_WRITE (1'b1)
    ) dut (
        .pll_core_cpuclk  (clk),
        .pad_cpu_rst_b    (rst_b),
        .pad_biu_bigend_b (bigend_b),
        .req_vld          (req_vld),
        .req_rdy          (req_rdy),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .req_size         (req_size),
        .req_wdata        (req_wdata),
        .resp_vld         (resp_vld),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [2:0] s, input logic [31:0] wd);
        req_vld   = v;
        req_write = w;
        req_addr  = a;
        req_size  = s;
        req_wdata = wd;
    endtask

    task automatic slave(input logic rdy, input logic [1:0] resp,
                         input logic [31:0] rd);
        bus.mst_hready = rdy;
        bus.mst_hresp  = resp;
        bus.mst_hrdata = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

    initial begin
        bigend_b = 1'b1;
        idle();
        slave(1'b1, 2'b00, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_htrans", 32'(bus.mst_yy_htrans), 32'h0);
        chk("rst_haddr", bus.mst_yy_haddr, 32'h0);
        chk("rst_hwdata", bus.mst_yy_hwdata, 32'h0);
        chk("rst_req_rdy", 32'(req_rdy), 32'h1);
        chk("rst_resp_vld", 32'(resp_vld), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        rst_b = 1'b1;

        // Little-endian word write then byte read
        tick();
        drive(1'b1, 1'b1, 32'h100, 3'd2, 32'h1234_5678);
        #1;
        chk("le_rdy0", 32'(req_rdy), 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h101, 3'd0, 32'h0);
        #1;
        chk("le_htrans1", 32'(bus.mst_yy_htrans), 32'h2);
        chk("le_haddr1", bus.mst_yy_haddr, 32'h100);
        chk("le_hwrite1", 32'(bus.mst_yy_hwrite), 32'h1);
        chk("le_hsize1", 32'(bus.mst_yy_hsize), 32'h2);
        tick();
        idle();
        #1;
        chk("le_htrans2", 32'(bus.mst_yy_htrans), 32'h2);
        chk("le_haddr2", bus.mst_yy_haddr, 32'h101);
        chk("le_hsize2", 32'(bus.mst_yy_hsize), 32'h0);
        chk("le_hwdata2", bus.mst_yy_hwdata, 32'h1234_5678);
        chk("le_wresp", 32'(resp_vld), 32'h1);
        chk("le_werr", 32'(resp_err), 32'h0);
        tick();
        slave(1'b1, 2'b00, 32'h1234_5678);
        #1;
        chk("le_rresp", 32'(resp_vld), 32'h1);
        chk("le_rdata", resp_rdata, 32'h0000_0056);
        chk("le_rerr", 32'(resp_err), 32'h0);
        chk("le_idle", 32'(bus.mst_yy_htrans), 32'h0);
        tick();
        #1;
        chk("le_noresp", 32'(resp_vld), 32'h0);

        // Big-endian byte and half reads
        bigend_b = 1'b0;
        drive(1'b1, 1'b0, 32'h100, 3'd0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h102, 3'd1, 32'h0);
        #1;
        chk("be_haddr1", bus.mst_yy_haddr, 32'h100);
        tick();
        idle();
        slave(1'b1, 2'b00, 32'hAABB_CCDD);
        #1;
        chk("be_haddr2", bus.mst_yy_haddr, 32'h102);
        chk("be_byte", resp_rdata, 32'h0000_00AA);
        tick();
        #1;
        chk("be_half", resp_rdata, 32'h0000_CCDD);
        chk("be_half_vld", 32'(resp_vld), 32'h1);
        tick();
        bigend_b = 1'b1;

        // Wait states with a request pending in the address phase
        drive(1'b1, 1'b0, 32'h200, 3'd2, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h204, 3'd2, 32'h0);
        #1;
        chk("ws_haddr0", bus.mst_yy_haddr, 32'h200);
        tick();
        drive(1'b1, 1'b0, 32'h208, 3'd2, 32'h0);
        slave(1'b0, 2'b00, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_htrans", 32'(bus.mst_yy_htrans), 32'h2);
            chk("ws_haddr", bus.mst_yy_haddr, 32'h204);
            chk("ws_req_rdy", 32'(req_rdy), 32'h0);
            chk("ws_resp_vld", 32'(resp_vld), 32'h0);
            tick();
        end
        slave(1'b1, 2'b00, 32'h1111_1111);
        #1;
        chk("ws_resp1", 32'(resp_vld), 32'h1);
        chk("ws_rdata1", resp_rdata, 32'h1111_1111);
        chk("ws_rdy1", 32'(req_rdy), 32'h1);
        tick();
        idle();
        slave(1'b1, 2'b00, 32'h2222_2222);
        #1;
        chk("ws_rdata2", resp_rdata, 32'h2222_2222);
        chk("ws_haddr3", bus.mst_yy_haddr, 32'h208);
        tick();
        slave(1'b1, 2'b00, 32'h3333_3333);
        #1;
        chk("ws_rdata3", resp_rdata, 32'h3333_3333);
        tick();
        #1;
        chk("ws_done", 32'(resp_vld), 32'h0);

        // Illegal word request between two legal reads
        drive(1'b1, 1'b0, 32'h300, 3'd2, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h102, 3'd2, 32'h0);
        #1;
        chk("il_haddr0", bus.mst_yy_haddr, 32'h300);
        tick();
        drive(1'b1, 1'b0, 32'h304, 3'd2, 32'h0);
        slave(1'b1, 2'b00, 32'hA5A5_A5A5);
        #1;
        chk("il_no_nonseq", 32'(bus.mst_yy_htrans), 32'h0);
        chk("il_resp1", 32'(resp_vld), 32'h1);
        chk("il_err1", 32'(resp_err), 32'h0);
        chk("il_rdata1", resp_rdata, 32'hA5A5_A5A5);
        tick();
        idle();
        #1;
        chk("il_resp2", 32'(resp_vld), 32'h1);
        chk("il_err2", 32'(resp_err), 32'h1);
        chk("il_rdata2", resp_rdata, 32'h0);
        chk("il_htrans3", 32'(bus.mst_yy_htrans), 32'h2);
        chk("il_haddr3", bus.mst_yy_haddr, 32'h304);
        tick();
        slave(1'b1, 2'b00, 32'h5A5A_5A5A);
        #1;
        chk("il_err3", 32'(resp_err), 32'h0);
        chk("il_rdata3", resp_rdata, 32'h5A5A_5A5A);
        tick();
        #1;
        chk("il_done", 32'(resp_vld), 32'h0);

        // Two-cycle ERROR on the first of two back-to-back writes
        drive(1'b1, 1'b1, 32'h400, 3'd2, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b1, 32'h404, 3'd2, 32'hCAFE_F00D);
        #1;
        chk("er_haddr0", bus.mst_yy_haddr, 32'h400);
        tick();
        idle();
        slave(1'b0, 2'b01, 32'h0);
        #1;
        chk("er_htrans1", 32'(bus.mst_yy_htrans), 32'h2);
        chk("er_haddr1", bus.mst_yy_haddr, 32'h404);
        chk("er_hwdata1", bus.mst_yy_hwdata, 32'hDEAD_BEEF);
        chk("er_resp1", 32'(resp_vld), 32'h0);
        tick();
        slave(1'b1, 2'b01, 32'h0);
        #1;
        chk("er_htrans2", 32'(bus.mst_yy_htrans), 32'h0);
        chk("er_resp2", 32'(resp_vld), 32'h1);
        chk("er_err2", 32'(resp_err), 32'h1);
        chk("er_rdy2", 32'(req_rdy), 32'h0);
        tick();
        slave(1'b1, 2'b00, 32'h0);
        #1;
        chk("er_reissue", 32'(bus.mst_yy_htrans), 32'h2);
        chk("er_haddr3", bus.mst_yy_haddr, 32'h404);
        chk("er_resp3", 32'(resp_vld), 32'h0);
        tick();
        #1;
        chk("er_resp4", 32'(resp_vld), 32'h1);
        chk("er_err4", 32'(resp_err), 32'h0);
        chk("er_hwdata4", bus.mst_yy_hwdata, 32'hCAFE_F00D);
        tick();

        // Byte and half write replication
        drive(1'b1, 1'b1, 32'h601, 3'd0, 32'hFFFF_FFAB);
        tick();
        drive(1'b1, 1'b1, 32'h602, 3'd1, 32'h0000_1234);
        tick();
        idle();
        #1;
        chk("rep_byte", bus.mst_yy_hwdata, 32'hABAB_ABAB);
        tick();
        #1;
        chk("rep_half", bus.mst_yy_hwdata, 32'h1234_1234);
        tick();

        // Reset while both stages hold a request
        drive(1'b1, 1'b0, 32'h500, 3'd2, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h504, 3'd2, 32'h0);
        tick();
        idle();
        #1;
        chk("rs_pre_htrans", 32'(bus.mst_yy_htrans), 32'h2);
        chk("rs_pre_resp", 32'(resp_vld), 32'h1);
        slave(1'b0, 2'b00, 32'h0);
        #1;
        chk("rs_pre_rdy", 32'(req_rdy), 32'h0);
        rst_b = 1'b0;
        #1;
        chk("rs_htrans", 32'(bus.mst_yy_htrans), 32'h0);
        chk("rs_rdy", 32'(req_rdy), 32'h1);
        slave(1'b1, 2'b00, 32'h0);
        #1;
        chk("rs_resp", 32'(resp_vld), 32'h0);
        tick();
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_no_stale", 32'(resp_vld), 32'h0);
            chk("rs_idle", 32'(bus.mst_yy_htrans), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
